// File: rtl/dice_roll_capture_if.sv
// dice_roll_capture_if: button/face inputs and capture/statistics outputs of the dice roll capture block.
// The pips output exists only when DICE_PIPS_EN is defined.
interface dice_roll_capture_if #(
    parameter int TALLY_W = 8
);
    logic [2:0]         face;
    logic               btn;
    logic [2:0]         tally_sel;
    logic               roll_active;
    logic [2:0]         result;
    logic               result_valid;
    logic               bad_face;
    logic [TALLY_W-1:0] tally;
`ifdef DICE_PIPS_EN
    logic [6:0]         pips;
    modport master (output face, btn, tally_sel,
                    input roll_active, result, result_valid, bad_face, tally, pips);
    modport slave  (input face, btn, tally_sel,
                    output roll_active, result, result_valid, bad_face, tally, pips);
`else
    modport master (output face, btn, tally_sel,
                    input roll_active, result, result_valid, bad_face, tally);
    modport slave  (input face, btn, tally_sel,
                    output roll_active, result, result_valid, bad_face, tally);
`endif
endinterface

// File: rtl/dice_roll_capture.sv
// dice_roll_capture: debounces the roll button, captures the live face on release and keeps saturating tallies.
// Optional 7-LED pips output enabled by defining DICE_PIPS_EN.
module dice_roll_capture #(
    parameter int DEB_CYC = 4,
    parameter int TALLY_W = 8
) (
    input logic                clock,
    input logic                reset_n,
    dice_roll_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROLL, CAPTURE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic               btn_db_q, btn_db_d;
    logic [7:0]         deb_cnt_q, deb_cnt_d;
    logic [2:0]         result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               bad_face_q, bad_face_d;
    logic [TALLY_W-1:0] tally_q [1:6];
    logic [TALLY_W-1:0] tally_d [1:6];
    logic               rise, fall, legal, cap;

    always_comb begin
        sync_d    = {sync_q[0], bus.btn};
        btn_db_d  = btn_db_q;
        deb_cnt_d = 8'd0;
        // A level change is accepted only after DEB_CYC consecutive differing samples
        if (sync_q[1] != btn_db_q) begin
            if (deb_cnt_q == 8'(DEB_CYC - 1)) btn_db_d = ~btn_db_q;
            else deb_cnt_d = deb_cnt_q + 8'd1;
        end
        rise    = btn_db_d & ~btn_db_q;
        fall    = ~btn_db_d & btn_db_q;
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: state_d = rise ? ROLL : state_q;
            ROLL:       state_d = fall ? CAPTURE : ROLL;
            CAPTURE:    state_d = HOLD;
            default:    state_d = IDLE;
        endcase
        legal          = bus.face != 3'd0 && bus.face != 3'd7;
        cap            = state_q == CAPTURE;
        result_valid_d = cap & legal;
        result_d       = result_valid_d ? bus.face : result_q;
        bad_face_d     = bad_face_q | (cap & ~legal);
        for (int i = 1; i <= 6; i++)
            tally_d[i] = (result_valid_d && bus.face == 3'(i) && ~&tally_q[i]) ? tally_q[i] + TALLY_W'(1) : tally_q[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sync_q         <= 2'b00;
            btn_db_q       <= 1'b0;
            deb_cnt_q      <= 8'd0;
            result_q       <= 3'd0;
            result_valid_q <= 1'b0;
            bad_face_q     <= 1'b0;
            for (int i = 1; i <= 6; i++) tally_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            btn_db_q       <= btn_db_d;
            deb_cnt_q      <= deb_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            bad_face_q     <= bad_face_d;
            for (int i = 1; i <= 6; i++) tally_q[i] <= tally_d[i];
        end
    end

    assign bus.roll_active  = state_q == ROLL;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.bad_face     = bad_face_q;
    assign bus.tally        = (bus.tally_sel != 3'd0 && bus.tally_sel != 3'd7) ? tally_q[bus.tally_sel] : '0;

`ifdef DICE_PIPS_EN
    logic [6:0] pips_q, pips_d;

    function automatic logic [6:0] pip_pattern(input logic [2:0] f);
        case (f)
            3'd1:    return 7'h08;
            3'd2:    return 7'h41;
            3'd3:    return 7'h49;
            3'd4:    return 7'h63;
            3'd5:    return 7'h6B;
            3'd6:    return 7'h77;
            default: return 7'h00;
        endcase
    endfunction

    // Show the spinning face while rolling, the captured result otherwise
    always_comb pips_d = pip_pattern(state_q == ROLL ? bus.face : result_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pips_q <= 7'h00;
        else pips_q <= pips_d;
    end

    assign bus.pips = pips_q;
`endif
endmodule

// File: tb/tb_dice_roll_capture.sv
// tb_dice_roll_capture: randomized rolls checked against a roll-level model of results, bad-face flag and tallies.
`timescale 1ns/1ps
module tb_dice_roll_capture;
    localparam int DEB  = 4;
    localparam int TW   = 2;
    localparam int TMAX = (1 << TW) - 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int cnt [1:6];
    logic [2:0] exp_result;
    logic exp_bad;

    dice_roll_capture_if #(.TALLY_W(TW)) bus();
    dice_roll_capture #(.DEB_CYC(DEB), .TALLY_W(TW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_tally(input int s);
        if (s < 1 || s > 6) return 0;
        return cnt[s] < TMAX ? cnt[s] : TMAX;
    endfunction

`ifdef DICE_PIPS_EN
    function automatic logic [6:0] pip_of(input logic [2:0] f);
        logic [6:0] t [8] = '{7'h00, 7'h08, 7'h41, 7'h49, 7'h63, 7'h6B, 7'h77, 7'h00};
        return t[f];
    endfunction
`endif

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) cnt[i] = 0;
        exp_result = 3'd0;
        exp_bad = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_result"}, bus.result, exp_result);
        check({tag, "_bad"}, bus.bad_face, exp_bad);
`ifdef DICE_PIPS_EN
        check({tag, "_pips"}, bus.pips, pip_of(exp_result));
`endif
        for (int s = 0; s < 8; s++) begin
            bus.tally_sel = 3'(s);
            #1;
            check($sformatf("%s_tally%0d", tag, s), bus.tally, exp_tally(s));
        end
    endtask

    task automatic press(input int hold);
        int lat = 0;
        int pulses = 0;
        logic was_act;
        bus.btn = 1'b1;
        for (int c = 0; c < hold; c++) begin
            bus.face = 3'($urandom_range(1, 6));
            was_act = bus.roll_active;
            step();
`ifdef DICE_PIPS_EN
            if (was_act) check("pips_roll", bus.pips, pip_of(bus.face));
`endif
            if (bus.result_valid) pulses++;
            if (lat == 0 && bus.roll_active) lat = c + 1;
        end
        check("press_latency_ok", lat >= 1 && lat <= DEB + 3, 1);
        check("press_pulses", pulses, 0);
    endtask

    task automatic release_roll(input logic [2:0] f);
        int pulses = 0;
        bit legal = f >= 1 && f <= 6;
        bus.face = f;
        bus.btn = 1'b0;
        for (int c = 0; c < DEB + 8; c++) begin
            step();
            if (bus.result_valid) pulses++;
        end
        if (legal) begin
            exp_result = f;
            cnt[f]++;
        end else exp_bad = 1'b1;
        check($sformatf("pulses_face%0d", f), pulses, legal ? 1 : 0);
        check("roll_ended", bus.roll_active, 0);
        check_all($sformatf("after_face%0d", f));
    endtask

    initial begin
        int act = 0, pul = 0, lat = 0;
        model_reset();
        bus.btn = 1'b1;
        bus.face = 3'd4;
        bus.tally_sel = 3'd0;
        repeat (3) step();
        check("rst_roll_active", bus.roll_active, 0);
        check("rst_valid", bus.result_valid, 0);
        check_all("rst");
        bus.btn = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            bus.btn = (c % 2 == 0);
            step();
            act += bus.roll_active;
            pul += bus.result_valid;
        end
        for (int g = 0; g < 10; g++) begin
            bus.btn = 1'b1;
            repeat ($urandom_range(1, DEB - 1)) begin step(); act += bus.roll_active; pul += bus.result_valid; end
            bus.btn = 1'b0;
            repeat ($urandom_range(2, 5)) begin step(); act += bus.roll_active; pul += bus.result_valid; end
        end
        repeat (8) begin step(); act += bus.roll_active; pul += bus.result_valid; end
        check("bounce_active", act, 0);
        check("bounce_pulses", pul, 0);

        press(20);
        release_roll(3'd3);

        for (int r = 0; r < 4; r++) begin
            press($urandom_range(DEB + 4, 15));
            release_roll(3'd5);
        end

        press(10);
        release_roll(3'd2);
        press(10);
        release_roll(3'd0);
        press(10);
        release_roll(3'($urandom_range(1, 6)));

        for (int r = 0; r < 15; r++) begin
            press($urandom_range(DEB + 4, 14));
            release_roll(3'($urandom_range(0, 7)));
        end

        press(12);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_roll_active", bus.roll_active, 0);
        check("midrst_valid", bus.result_valid, 0);
        model_reset();
        check_all("midrst");
        reset_n = 1'b1;
        pul = 0;
        for (int c = 0; c < DEB + 8; c++) begin
            step();
            pul += bus.result_valid;
            if (lat == 0 && bus.roll_active) lat = c + 1;
        end
        check("rearm_latency_ok", lat >= 1 && lat <= DEB + 3, 1);
        check("rearm_pulses", pul, 0);
        release_roll(3'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
